// File: rtl/game_pkg.sv
// Shared game types: round status, judge FSM states, grid geometry and bomb-tile codes.
package game_pkg;

    typedef enum logic [1:0] {
        NOT_OVER  = 2'd0,
        GAME_OVER = 2'd1,
        P1_WIN    = 2'd2,
        P2_WIN    = 2'd3
    } game_status_t;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_END_HOLD,
        ST_OVER
    } judge_state_t;

    localparam int GRID_TILES = 256;
    localparam int GRID_W     = 16;

    // Per-tile contents as tracked by the bomb stage
    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_WALL  = 2'd1,
        TILE_BRICK = 2'd2,
        TILE_BOMB  = 2'd3
    } tile_t;

    function automatic logic [7:0] tile_idx(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/player_life.sv
// One player's life count, post-hit invulnerability timer and hit pulse.
module player_life
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       enable,
    input  logic       burning,
    output logic [1:0] lives,
    output logic       invuln,
    output logic       hit
);

    logic [5:0] inv_cnt;
    logic       take;

    assign take   = enable & burning & (inv_cnt == 6'd0);
    assign invuln = (inv_cnt != 6'd0);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            lives   <= 2'(LIVES_INIT);
            inv_cnt <= 6'd0;
            hit     <= 1'b0;
        end else begin
            hit <= take;
            if (take) begin
                inv_cnt <= 6'(INVULN_FRAMES);
                if (lives != 2'd0)
                    lives <= lives - 2'd1;
            end else if (inv_cnt != 6'd0) begin
                // timer keeps running in every state so it drains during the end hold too
                inv_cnt <= inv_cnt - 6'd1;
            end
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Blast hit detection for both players, round decision FSM and end-of-round hold.
module hit_judge
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int END_HOLD      = 90
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [GRID_TILES-1:0] explode,
    input  logic [7:0]            p1_cor,
    input  logic [7:0]            p2_cor,
    output logic [1:0]            p1_lives,
    output logic [1:0]            p2_lives,
    output logic                  p1_invuln,
    output logic                  p2_invuln,
    output logic                  p1_hit,
    output logic                  p2_hit,
    output logic [1:0]            game_status,
    output logic                  freeze,
    output logic                  round_done
);

    localparam logic [6:0] END_LAST = 7'(END_HOLD - 1);

    judge_state_t state;
    game_status_t status;
    logic [6:0]   end_cnt;
    logic         play_en;
    logic         p1_burn, p2_burn;
    logic         p1_dead, p2_dead;

    assign play_en = (state == ST_PLAY) & ~start;
    assign p1_burn = explode[p1_cor];
    assign p2_burn = explode[p2_cor];

    player_life #(.LIVES_INIT(LIVES_INIT), .INVULN_FRAMES(INVULN_FRAMES)) u_p1 (
        .clk     (clk),
        .reset   (reset),
        .restart (start),
        .enable  (play_en),
        .burning (p1_burn),
        .lives   (p1_lives),
        .invuln  (p1_invuln),
        .hit     (p1_hit)
    );

    player_life #(.LIVES_INIT(LIVES_INIT), .INVULN_FRAMES(INVULN_FRAMES)) u_p2 (
        .clk     (clk),
        .reset   (reset),
        .restart (start),
        .enable  (play_en),
        .burning (p2_burn),
        .lives   (p2_lives),
        .invuln  (p2_invuln),
        .hit     (p2_hit)
    );

    // Decide on the lives value the players will hold after this edge
    assign p1_dead = (p1_lives == 2'd0) | (p1_burn & ~p1_invuln & (p1_lives == 2'd1));
    assign p2_dead = (p2_lives == 2'd0) | (p2_burn & ~p2_invuln & (p2_lives == 2'd1));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            state      <= ST_PLAY;
            status     <= NOT_OVER;
            end_cnt    <= 7'd0;
            freeze     <= 1'b0;
            round_done <= 1'b0;
        end else begin
            round_done <= 1'b0;
            case (state)
                ST_PLAY: begin
                    if (p1_dead || p2_dead) begin
                        state   <= ST_END_HOLD;
                        freeze  <= 1'b1;
                        end_cnt <= 7'd0;
                        if (p1_dead && p2_dead) status <= GAME_OVER;
                        else if (p1_dead)       status <= P2_WIN;
                        else                    status <= P1_WIN;
                    end
                end
                ST_END_HOLD: begin
                    if (end_cnt == END_LAST) begin
                        state      <= ST_OVER;
                        round_done <= 1'b1;
                    end else begin
                        end_cnt <= end_cnt + 7'd1;
                    end
                end
                ST_OVER: freeze <= 1'b1;
                default: begin
                    state  <= ST_PLAY;
                    freeze <= 1'b0;
                end
            endcase
        end
    end

    assign game_status = status;

endmodule
